// File: rtl/adc_trigger.sv
// adc_trigger: level/slope trigger with hysteresis and auto timeout, gating DEPTH samples to the buffer
module adc_trigger #(
  parameter int DW = 8,
  parameter int DEPTH = 8192,
  parameter int HYST = 4,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic          osc_clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_data,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic          auto_mode,
  input  logic          rearm,
  output logic          write_enable,
  output logic [DW-1:0] write_data,
  output logic          capture_done,
  output logic          triggered,
  output logic          armed
);
  localparam int WW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [DW:0] HY = (DW + 1)'(HYST);
  localparam logic [DW:0] TOP = {1'b0, {DW{1'b1}}};
  typedef enum logic [1:0] {PRIME, ARMED, CAPTURE, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [DW-1:0] level_q, wd_n;
  logic slope_q, auto_q, we_n, trig_n, done_n;
  logic [DW:0] lvl_x, smp_x, lo, hi_raw, hi;
  logic waiting, hit, prime_ok, timeout, start, write, last;
  assign lvl_x    = {1'b0, level_q};
  assign smp_x    = {1'b0, sample_data};
  assign lo       = lvl_x < HY ? '0 : lvl_x - HY;
  assign hi_raw   = lvl_x + HY;
  assign hi       = hi_raw > TOP ? TOP : hi_raw;
  assign waiting  = state == PRIME || state == ARMED;
  assign hit      = state == ARMED && (slope_q ? sample_data >= level_q : sample_data <= level_q);
  assign prime_ok = state == PRIME && (slope_q ? smp_x <= lo : smp_x >= hi);
  assign timeout  = auto_q && tcnt == TW'(AUTO_TIMEOUT - 1);
  assign start    = waiting && (hit || timeout);
  assign write    = start || state == CAPTURE;
  assign last     = start ? DEPTH == 1 : wcnt == WW'(DEPTH - 1);
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    wcnt_n  = wcnt;
    trig_n  = triggered;
    done_n  = capture_done;
    we_n    = 1'b0;
    wd_n    = write_data;
    if (rearm) begin
      state_n = PRIME;
      tcnt_n  = '0;
      wcnt_n  = '0;
      trig_n  = 1'b0;
      done_n  = 1'b0;
    end else if (sample_valid) begin
      if (write) begin
        we_n    = 1'b1;
        wd_n    = sample_data;
        wcnt_n  = start ? WW'(1) : wcnt + 1'b1;
        state_n = last ? DONE : CAPTURE;
        done_n  = last;
        trig_n  = start ? hit : triggered;
      end else if (prime_ok) begin
        state_n = ARMED;
      end
      if (waiting && !start)
        tcnt_n = tcnt == TW'(AUTO_TIMEOUT) ? tcnt : tcnt + 1'b1;
    end
  end
  // config is sampled only at reset/rearm so mid-capture changes are ignored
  always_ff @(posedge osc_clk) begin
    if (reset || rearm) begin
      level_q <= trig_level;
      slope_q <= trig_slope;
      auto_q  <= auto_mode;
    end
    if (reset) begin
      state        <= PRIME;
      tcnt         <= '0;
      wcnt         <= '0;
      write_enable <= 1'b0;
      write_data   <= '0;
      capture_done <= 1'b0;
      triggered    <= 1'b0;
      armed        <= 1'b0;
    end else begin
      state        <= state_n;
      tcnt         <= tcnt_n;
      wcnt         <= wcnt_n;
      write_enable <= we_n;
      write_data   <= wd_n;
      capture_done <= done_n;
      triggered    <= trig_n;
      armed        <= state_n == ARMED;
    end
  end
endmodule
